sc_ir_fetch_ctrl: RTL and testbench
===================================

# sc_ir_fetch_ctrl

Fetch/decode sequencer for the micro-datapath instruction register. It issues instruction-memory read requests and drives the instruction register's write strobe when read data is valid. It pulses the PC increment, checks the fetched opcode for HALT, and holds the execute phase open until the datapath signals completion. It sits between the instruction memory, the PC register, the instruction register and the execution datapath.

## Interface
- DATAWIDTH_BUS, 32, width of instruction word returned from IR output
- OPCODE_WIDTH, 8, opcode field = IR[DATAWIDTH_BUS-1 -: OPCODE_WIDTH]
- HALT_OPCODE, 8'hFF, opcode value that stops the sequencer
- TIMEOUT_CYCLES, 16, fetch watchdog limit (used only with FETCH_TIMEOUT_EN), range 2..255
- SC_RegGENERAL_CLOCK_50  in  1  system clock, rising edge
- SC_RegGENERAL_Reset_InHigh  in  1  reset, asynchronous, active-high
- SC_FetchCtrl_Start_InHigh  in  1  run enable; level-sensitive
- SC_FetchCtrl_MemAck_InHigh  in  1  instruction memory data valid this cycle
- SC_FetchCtrl_IR_In  in  DATAWIDTH_BUS  current instruction register contents
- SC_FetchCtrl_ExecDone_InHigh  in  1  datapath finished executing current instruction
- SC_FetchCtrl_MemReq_OutHigh  out  1  instruction memory read request
- SC_FetchCtrl_IRWrite_OutHigh  out  1  write strobe to instruction register
- SC_FetchCtrl_PCInc_OutHigh  out  1  PC increment strobe
- SC_FetchCtrl_Exec_OutHigh  out  1  execute phase active
- SC_FetchCtrl_Halted_OutHigh  out  1  HALT opcode decoded
- SC_FetchCtrl_Error_OutHigh  out  1  fetch timeout occurred
- SC_FetchCtrl_State_Out  out  3  current state encoding
- SC_FetchCtrl_InstrCount_Out  out  16  retired instruction count

## Operation
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, HALT=4, ERROR=5; 6, 7 unreachable and recover to IDLE.
- IDLE: if Start=1, go to FETCH; otherwise stay.
- FETCH: MemReq=1. If MemAck=1, IRWrite=1 and PCInc=1 combinationally in the same cycle, so the IR captures memory data on that edge; next state is DECODE. If MemAck=0, stay.
- DECODE: one cycle; IR_In now holds the new instruction. Opcode == HALT_OPCODE goes to HALT; otherwise EXEC.
- EXEC: Exec=1. On ExecDone=1, InstrCount increments (wraps 16'hFFFF to 0). Next state is FETCH if Start=1, else IDLE.
- HALT: Halted=1, MemReq=0. Sticky until reset; Start ignored. HALT is not counted as retired.
- ERROR: Error=1. Sticky until reset.
- Output decoding: MemReq, Exec, Halted and Error are decoded from registered state (Moore). IRWrite and PCInc are Mealy (FETCH && MemAck), so each is exactly 1 cycle per fetch.
- Start deasserted mid-instruction does not abort; the current instruction completes, then the block returns to IDLE.
- MemAck outside FETCH and ExecDone outside EXEC are ignored.
- Reset (any time, including mid-fetch): state goes to IDLE and InstrCount and the watchdog counter go to 0. All outputs read 0 at reset: MemReq, IRWrite, PCInc, Exec, Halted, Error, State=0, InstrCount=0.

## Timing
- Start sampled high at edge N: FETCH during cycle N+1, with MemReq high.
- MemAck high in FETCH cycle K: IRWrite/PCInc high in cycle K; DECODE in K+1; EXEC in K+2.
- Minimum instruction period (ack and done both immediate): 3 cycles (FETCH, DECODE, EXEC).
- ExecDone in EXEC cycle M: InstrCount updated and next state taken at the edge ending cycle M.
- Watchdog (when enabled): counter cleared on entry to FETCH; increments each FETCH cycle with MemAck=0. The transition to ERROR occurs at the edge ending the TIMEOUT_CYCLES-th consecutive un-acked FETCH cycle.
- If MemAck=1 arrives in that final cycle, the ack wins: normal capture, no error.

## Configuration
- FETCH_TIMEOUT_EN defined: watchdog counter and ERROR state are present and behave as above.
- FETCH_TIMEOUT_EN undefined: no watchdog is built, FETCH waits for MemAck indefinitely, ERROR is unreachable, and Error_OutHigh is tied to 0.

## Test plan
- Reset, then Start=1; MemAck in the 1st FETCH cycle with IR_In opcode 8'h01; ExecDone on the 1st EXEC cycle. Required: State sequence 1,2,3,1; IRWrite and PCInc each high exactly 1 cycle; InstrCount=1.
- Hold MemAck low for 3 FETCH cycles, then high. Required: MemReq high for 4 cycles; IRWrite pulses only in the 4th; no Error.
- Fetch an instruction whose IR_In opcode is 8'hFF. Required: DECODE then HALT; Halted=1; MemReq stays 0; InstrCount unchanged; Start toggling has no effect.
- Drop Start during EXEC, then ExecDone=1. Required: next state IDLE; InstrCount increments. Start=1 again: FETCH resumes.
- With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=16: no MemAck for 16 cycles gives Error=1 and State=5. Repeat with MemAck in the 16th cycle: normal capture, Error=0.
- Assert reset mid-FETCH and mid-EXEC with InstrCount=5. Required: all outputs 0 immediately (asynchronous), State=0, InstrCount=0.

Source files
------------

// File: rtl/sc_ir_fetch_ctrl.sv
// Fetch/decode/execute sequencer for the micro-datapath instruction register.
// Optional fetch watchdog and ERROR state: define FETCH_TIMEOUT_EN.
module sc_ir_fetch_ctrl #(
  parameter int DATAWIDTH_BUS = 32,
  parameter int OPCODE_WIDTH = 8,
  parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE = 8'hFF,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     SC_RegGENERAL_CLOCK_50,
  input  logic                     SC_RegGENERAL_Reset_InHigh,
  input  logic                     SC_FetchCtrl_Start_InHigh,
  input  logic                     SC_FetchCtrl_MemAck_InHigh,
  input  logic [DATAWIDTH_BUS-1:0] SC_FetchCtrl_IR_In,
  input  logic                     SC_FetchCtrl_ExecDone_InHigh,
  output logic                     SC_FetchCtrl_MemReq_OutHigh,
  output logic                     SC_FetchCtrl_IRWrite_OutHigh,
  output logic                     SC_FetchCtrl_PCInc_OutHigh,
  output logic                     SC_FetchCtrl_Exec_OutHigh,
  output logic                     SC_FetchCtrl_Halted_OutHigh,
  output logic                     SC_FetchCtrl_Error_OutHigh,
  output logic [2:0]               SC_FetchCtrl_State_Out,
  output logic [15:0]              SC_FetchCtrl_InstrCount_Out
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    HALT   = 3'd4,
    ERROR  = 3'd5
  } state_t;

  state_t stateReg;
  state_t stateNext;
  logic [15:0] instrCount;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic wdExpire;

  assign opcode = SC_FetchCtrl_IR_In[DATAWIDTH_BUS-1 -: OPCODE_WIDTH];

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] WdLast = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wdCnt;

  // Counter holds the number of un-acked FETCH cycles already elapsed
  always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_Reset_InHigh) begin
    if (SC_RegGENERAL_Reset_InHigh) begin
      wdCnt <= '0;
    end else if (stateReg != FETCH) begin
      wdCnt <= '0;
    end else if (!SC_FetchCtrl_MemAck_InHigh) begin
      wdCnt <= wdCnt + 8'd1;
    end
  end

  assign wdExpire = (wdCnt == WdLast);
`else
  localparam int unusedTimeout = TIMEOUT_CYCLES;
  assign wdExpire = 1'b0;
`endif

  always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_Reset_InHigh) begin
    if (SC_RegGENERAL_Reset_InHigh) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = IDLE;
    case (stateReg)
      IDLE: begin
        stateNext = SC_FetchCtrl_Start_InHigh ? FETCH : IDLE;
      end
      FETCH: begin
        if (SC_FetchCtrl_MemAck_InHigh) begin
          stateNext = DECODE;
        end else if (wdExpire) begin
          stateNext = ERROR;
        end else begin
          stateNext = FETCH;
        end
      end
      DECODE: begin
        stateNext = (opcode == HALT_OPCODE) ? HALT : EXEC;
      end
      EXEC: begin
        if (!SC_FetchCtrl_ExecDone_InHigh) begin
          stateNext = EXEC;
        end else if (SC_FetchCtrl_Start_InHigh) begin
          stateNext = FETCH;
        end else begin
          stateNext = IDLE;
        end
      end
      HALT:    stateNext = HALT;
      ERROR:   stateNext = ERROR;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_Reset_InHigh) begin
    if (SC_RegGENERAL_Reset_InHigh) begin
      instrCount <= '0;
    end else if (stateReg == EXEC && SC_FetchCtrl_ExecDone_InHigh) begin
      instrCount <= instrCount + 16'd1;
    end
  end

  // Capture strobes are Mealy so the IR loads on the same edge as the ack
  always_comb begin
    SC_FetchCtrl_MemReq_OutHigh  = (stateReg == FETCH);
    SC_FetchCtrl_IRWrite_OutHigh = (stateReg == FETCH) && SC_FetchCtrl_MemAck_InHigh;
    SC_FetchCtrl_PCInc_OutHigh   = (stateReg == FETCH) && SC_FetchCtrl_MemAck_InHigh;
    SC_FetchCtrl_Exec_OutHigh    = (stateReg == EXEC);
    SC_FetchCtrl_Halted_OutHigh  = (stateReg == HALT);
`ifdef FETCH_TIMEOUT_EN
    SC_FetchCtrl_Error_OutHigh   = (stateReg == ERROR);
`else
    SC_FetchCtrl_Error_OutHigh   = 1'b0;
`endif
    SC_FetchCtrl_State_Out       = stateReg;
    SC_FetchCtrl_InstrCount_Out  = instrCount;
  end

endmodule

// File: tb/tb_sc_ir_fetch_ctrl.sv
// Scoreboard bench for sc_ir_fetch_ctrl: per-cycle expected outputs
// are queued by the stimulus and checked by an independent monitor.
module tb_sc_ir_fetch_ctrl;

  localparam logic [5:0] F_NONE = 6'b000000;
  localparam logic [5:0] F_REQ  = 6'b100000;
  localparam logic [5:0] F_CAP  = 6'b111000;
  localparam logic [5:0] F_EXE  = 6'b000100;
  localparam logic [5:0] F_HLT  = 6'b000010;
  localparam logic [5:0] F_ERR  = 6'b000001;

  typedef struct {
    string       name;
    logic [2:0]  st;
    logic [5:0]  fl;
    logic [15:0] cnt;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        ack;
  logic [31:0] ir;
  logic        done;
  logic        memReq;
  logic        irWrite;
  logic        pcInc;
  logic        exec;
  logic        halted;
  logic        error;
  logic [2:0]  state;
  logic [15:0] count;

  exp_t sb[$];
  exp_t mon;
  logic [5:0] act;
  int checks = 0;
  int fails = 0;

  sc_ir_fetch_ctrl dut (
    .SC_RegGENERAL_CLOCK_50      (clk),
    .SC_RegGENERAL_Reset_InHigh  (rst),
    .SC_FetchCtrl_Start_InHigh   (start),
    .SC_FetchCtrl_MemAck_InHigh  (ack),
    .SC_FetchCtrl_IR_In          (ir),
    .SC_FetchCtrl_ExecDone_InHigh(done),
    .SC_FetchCtrl_MemReq_OutHigh (memReq),
    .SC_FetchCtrl_IRWrite_OutHigh(irWrite),
    .SC_FetchCtrl_PCInc_OutHigh  (pcInc),
    .SC_FetchCtrl_Exec_OutHigh   (exec),
    .SC_FetchCtrl_Halted_OutHigh (halted),
    .SC_FetchCtrl_Error_OutHigh  (error),
    .SC_FetchCtrl_State_Out      (state),
    .SC_FetchCtrl_InstrCount_Out (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon = sb.pop_front();
      act = {memReq, irWrite, pcInc, exec, halted, error};
      checks++;
      if (state !== mon.st || act !== mon.fl || count !== mon.cnt) begin
        fails++;
        $display("FAIL %s: got st=%0d fl=%b cnt=%0d, want st=%0d fl=%b cnt=%0d",
                 mon.name, state, act, count, mon.st, mon.fl, mon.cnt);
      end
    end
  end

  task automatic cyc(input string nm, input logic s, input logic a,
                     input logic d, input logic [31:0] instr,
                     input logic [2:0] st, input logic [5:0] fl,
                     input logic [15:0] c);
    exp_t e;
    start = s;
    ack = a;
    done = d;
    ir = instr;
    e.name = nm;
    e.st = st;
    e.fl = fl;
    e.cnt = c;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [15:0] c);
    cyc("fetch", 1, 1, 0, 32'h01000000, 3'd1, F_CAP, c);
    cyc("decode", 1, 0, 0, 32'h01000000, 3'd2, F_NONE, c);
    cyc("exec", 1, 0, 1, 32'h01000000, 3'd3, F_EXE, c);
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, want finish");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    ack = 1'b0;
    done = 1'b0;
    ir = '0;
    @(posedge clk);
    #1;
    cyc("reset", 0, 0, 0, 0, 3'd0, F_NONE, 0);
    rst = 1'b0;
    cyc("idle", 1, 0, 0, 0, 3'd0, F_NONE, 0);
    instr(0);

    cyc("wait1", 1, 0, 0, 0, 3'd1, F_REQ, 1);
    cyc("wait2", 1, 0, 0, 0, 3'd1, F_REQ, 1);
    cyc("wait3", 1, 0, 0, 0, 3'd1, F_REQ, 1);
    cyc("ack4", 1, 1, 0, 32'h02000000, 3'd1, F_CAP, 1);
    cyc("decDoneIgn", 1, 0, 1, 32'h02000000, 3'd2, F_NONE, 1);
    cyc("execHold", 0, 0, 0, 32'h02000000, 3'd3, F_EXE, 1);
    cyc("execDone", 0, 0, 1, 32'h02000000, 3'd3, F_EXE, 1);
    cyc("idleAckIgn", 0, 1, 0, 0, 3'd0, F_NONE, 2);
    cyc("restart", 1, 0, 0, 0, 3'd0, F_NONE, 2);
    cyc("haltFetch", 1, 1, 0, 32'hFF000000, 3'd1, F_CAP, 2);
    cyc("haltDec", 1, 0, 0, 32'hFF000000, 3'd2, F_NONE, 2);
    for (int i = 0; i < 4; i++) begin
      cyc("halted", logic'(i[0]), 1, 1, 32'hFF000000, 3'd4, F_HLT, 2);
    end

    rst = 1'b1;
    cyc("rstHalt", 0, 0, 0, 0, 3'd0, F_NONE, 0);
    rst = 1'b0;
    cyc("idle2", 1, 0, 0, 0, 3'd0, F_NONE, 0);
    for (int i = 0; i < 15; i++) begin
      cyc("noAck", 1, 0, 0, 0, 3'd1, F_REQ, 0);
    end
`ifdef FETCH_TIMEOUT_EN
    cyc("noAck16", 1, 0, 0, 0, 3'd1, F_REQ, 0);
    cyc("error", 1, 1, 0, 0, 3'd5, F_ERR, 0);
    cyc("errSticky", 1, 1, 1, 0, 3'd5, F_ERR, 0);
    rst = 1'b1;
    cyc("rstErr", 1, 0, 0, 0, 3'd0, F_NONE, 0);
    rst = 1'b0;
    cyc("idleRetry", 1, 0, 0, 0, 3'd0, F_NONE, 0);
    for (int i = 0; i < 15; i++) begin
      cyc("noAckRetry", 1, 0, 0, 0, 3'd1, F_REQ, 0);
    end
    cyc("ack16", 1, 1, 0, 32'h01000000, 3'd1, F_CAP, 0);
`else
    cyc("noAck16", 1, 0, 0, 0, 3'd1, F_REQ, 0);
    cyc("noAck17", 1, 0, 0, 0, 3'd1, F_REQ, 0);
    cyc("ack18", 1, 1, 0, 32'h01000000, 3'd1, F_CAP, 0);
`endif
    cyc("decAfterWait", 1, 0, 0, 32'h01000000, 3'd2, F_NONE, 0);
    cyc("execAfterWait", 1, 0, 1, 32'h01000000, 3'd3, F_EXE, 0);
    for (int i = 1; i < 5; i++) begin
      instr(16'(i));
    end
    cyc("fetchPreRst", 1, 0, 0, 0, 3'd1, F_REQ, 5);
    rst = 1'b1;
    cyc("rstFetch", 1, 1, 0, 0, 3'd0, F_NONE, 0);
    rst = 1'b0;
    cyc("idle3", 1, 0, 0, 0, 3'd0, F_NONE, 0);
    for (int i = 0; i < 5; i++) begin
      instr(16'(i));
    end
    cyc("fetch6", 1, 1, 0, 32'h03000000, 3'd1, F_CAP, 5);
    cyc("dec6", 1, 0, 0, 32'h03000000, 3'd2, F_NONE, 5);
    cyc("execPreRst", 1, 0, 0, 32'h03000000, 3'd3, F_EXE, 5);
    rst = 1'b1;
    cyc("rstExec", 1, 0, 1, 0, 3'd0, F_NONE, 0);
    rst = 1'b0;
    cyc("postRst", 0, 0, 0, 0, 3'd0, F_NONE, 0);

    @(negedge clk);
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
